// File: rtl/rpn_pkg.sv
// Shared key codes, op codes and FSM states for the RPN key decoder.
// RPN_HEX_EN widens the digit set to 0-F.
package rpn_pkg;

    localparam int unsigned KEY_ENTER = 16;
    localparam int unsigned KEY_NEG   = 17;
    localparam int unsigned KEY_ADD   = 18;
    localparam int unsigned KEY_MUL   = 19;
    localparam int unsigned KEY_CLEAR = 20;

    typedef enum logic [1:0] {
        OP_NONE = 2'd0,
        OP_NEG  = 2'd1,
        OP_ADD  = 2'd2,
        OP_MUL  = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        OP_PEND
    } state_e;

    function automatic logic is_digit(input int unsigned k);
`ifdef RPN_HEX_EN
        return k < 16;
`else
        return k < 10;
`endif
    endfunction

    function automatic op_e key_op(input int unsigned k);
        op_e o;
        case (k)
            KEY_NEG: o = OP_NEG;
            KEY_ADD: o = OP_ADD;
            KEY_MUL: o = OP_MUL;
            default: o = OP_NONE;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/rpn_digit_acc.sv
// Next-entry arithmetic: decimal multiply-add, or hex shift-or
// when RPN_HEX_EN is defined. Results wrap modulo 2^W.
module rpn_digit_acc #(
    parameter int W = 16
) (
    input  logic [W-1:0] entry_i,
    input  logic [3:0]   digit_i,
    output logic [W-1:0] next_o
);

`ifdef RPN_HEX_EN
    assign next_o = {entry_i[W-5:0], digit_i};
`else
    // x*10 as x*8 + x*2 keeps everything in W bits
    assign next_o = (entry_i << 3) + (entry_i << 1) + W'(digit_i);
`endif

endmodule

// File: rtl/rpn_key_decoder.sv
// Key-code front end for the RPN core: assembles operands and issues
// one-cycle push/op commands. RPN_HEX_EN enables hex digit entry.
module rpn_key_decoder
    import rpn_pkg::*;
#(
    parameter int W  = 16,
    parameter int KW = 5
) (
    input  logic          step,
    input  logic          nrst,
    input  logic          key_valid,
    input  logic [KW-1:0] key,
    output logic          key_ready,
    output logic          push,
    output logic [1:0]    op,
    output logic [W-1:0]  d,
    output logic [W-1:0]  entry,
    output logic          entry_active,
    output logic          err
);

    state_e         state_q;
    op_e            pend_q;
    op_e            op_q;
    logic           push_q;
    logic           err_q;
    logic [W-1:0]   d_q;
    logic [W-1:0]   entry_q;
    logic [W-1:0]   acc_nxt;
    logic [31:0]    key_u;
    logic           accept;
    logic           is_dig;
    logic           is_term;
    op_e            cmd;

    assign key_u   = 32'(key);
    assign accept  = key_valid & key_ready;
    assign is_dig  = is_digit(key_u);
    assign is_term = (key_u == KEY_ENTER) || (key_u == KEY_CLEAR);
    assign cmd     = key_op(key_u);

    rpn_digit_acc #(.W(W)) u_acc (
        .entry_i (entry_q),
        .digit_i (key[3:0]),
        .next_o  (acc_nxt)
    );

    always_ff @(posedge step or negedge nrst) begin
        if (!nrst) begin
            state_q <= IDLE;
            pend_q  <= OP_NONE;
            op_q    <= OP_NONE;
            push_q  <= 1'b0;
            err_q   <= 1'b0;
            d_q     <= '0;
            entry_q <= '0;
        end else begin
            push_q <= 1'b0;
            op_q   <= OP_NONE;
            err_q  <= 1'b0;
            if (state_q == OP_PEND) begin
                op_q    <= pend_q;
                pend_q  <= OP_NONE;
                state_q <= IDLE;
            end else if (accept) begin
                unique case (1'b1)
                    is_dig: begin
                        entry_q <= acc_nxt;
                        state_q <= ACCUM;
                    end
                    is_term: begin
                        if (state_q == ACCUM && key_u == KEY_ENTER) begin
                            push_q <= 1'b1;
                            d_q    <= entry_q;
                        end
                        entry_q <= '0;
                        state_q <= IDLE;
                    end
                    (cmd != OP_NONE): begin
                        // operator ends an entry: push now, op next cycle
                        if (state_q == ACCUM) begin
                            push_q  <= 1'b1;
                            d_q     <= entry_q;
                            pend_q  <= cmd;
                            entry_q <= '0;
                            state_q <= OP_PEND;
                        end else begin
                            op_q <= cmd;
                        end
                    end
                    default: err_q <= 1'b1;
                endcase
            end
        end
    end

    assign key_ready    = (state_q != OP_PEND);
    assign push         = push_q;
    assign op           = op_q;
    assign d            = d_q;
    assign entry        = entry_q;
    assign entry_active = (state_q == ACCUM);
    assign err          = err_q;

endmodule
